// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send, shifts out
// start/data/parity/stop on device clock falling edges and checks the device acknowledge.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYC = 10000,
    parameter int unsigned TIMEOUT_CYC = 1500000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned FRAME_W = 10;
    localparam int unsigned EDGE_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [EDGE_W-1:0]    edge_q, edge_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 clk_oe_q, clk_oe_d;
    logic                 data_oe_q, data_oe_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic clk_meta_q, clk_sync_q, clk_prev_q, fe_q;
    logic data_meta_q, data_sync_q;
    logic timeout_c;

    // Pin synchronizers; the falling-edge strobe is registered so the FSM acts one cycle later.
    always_ff @(posedge CLK) begin
        if (RST) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            fe_q        <= 1'b0;
        end else begin
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
            fe_q        <= clk_prev_q & ~clk_sync_q;
        end
    end

    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        frame_d   = frame_q;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (tx_start) begin
                    state_d  = S_INHIBIT;
                    cnt_d    = '0;
                    frame_d  = {1'b1, ~^tx_data, tx_data};
                    clk_oe_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            S_INHIBIT: begin
                clk_oe_d = 1'b1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(INHIBIT_CYC - 1)) begin
                    state_d   = S_REQ;
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                end
            end
            S_REQ: begin
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = S_SEND;
                    cnt_d    = '0;
                    clk_oe_d = 1'b0;
                    edge_d   = '0;
                end
            end
            S_SEND: begin
                data_oe_d = data_oe_q;
                cnt_d     = cnt_q + CNT_W'(1);
                if (fe_q) begin
                    cnt_d     = '0;
                    data_oe_d = ~frame_q[0];
                    frame_d   = {1'b0, frame_q[FRAME_W-1:1]};
                    edge_d    = edge_q + EDGE_W'(1);
                    if (edge_q == EDGE_W'(FRAME_W - 1)) begin
                        state_d = S_ACK;
                    end
                end else if (timeout_c) begin
                    state_d   = S_ERR;
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    data_oe_d = 1'b0;
                end
            end
            S_ACK: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (fe_q) begin
                    cnt_d = '0;
                    if (data_sync_q) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_WAIT_IDLE;
                    end
                end else if (timeout_c) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            S_WAIT_IDLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (clk_sync_q && data_sync_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (fe_q) begin
                    cnt_d = '0;
                end else if (timeout_c) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            edge_q    <= '0;
            frame_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            frame_q   <= frame_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign tx_busy     = busy_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural PS/2 device, fixed vectors,
// random frames against a frame model, and inhibit/timeout/reset/busy corner sequences.
module tb_ps2_host_tx;

    localparam int unsigned INH = 20;
    localparam int unsigned TMO = 200;

    logic       CLK;
    logic       RST;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy, tx_done, tx_err;
    logic       clk_oe, data_oe;
    logic       dev_clk_low, dev_data_low;
    logic       ps2_clk_line, ps2_data_line;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
    assign ps2_data_line = ~(data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
        .CLK(CLK),
        .RST(RST),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_err(tx_err),
        .ps2_clk_in(ps2_clk_line),
        .ps2_data_in(ps2_data_line),
        .ps2_clk_oe(clk_oe),
        .ps2_data_oe(data_oe)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        #1;
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (tx_done && tx_err) both_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  data;
        bit          ack;
        int          half;
        logic [10:0] exp_bits;
        int          exp_done;
        int          exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Line values a device sees: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    // Device: waits for request-to-send, then clocks n_edges, sampling data mid high phase.
    task automatic dev_xfer(input bit ack, input int half, input int n_edges,
                            output logic [10:0] bits, output bit ok);
        int t;
        bits = 'x;
        ok   = 1'b0;
        t = 0;
        while (!clk_oe && t < 50) begin @(negedge CLK); t++; end
        if (!clk_oe) return;
        t = 0;
        while (clk_oe && t < int'(INH) + 50) begin @(negedge CLK); t++; end
        if (clk_oe) return;
        ok = 1'b1;
        for (int i = 0; i < n_edges; i++) begin
            repeat (half / 2) @(negedge CLK);
            bits[i] = ps2_data_line;
            if (i == 10 && ack) dev_data_low = 1'b1;
            repeat (half - half / 2) @(negedge CLK);
            dev_clk_low = 1'b1;
            repeat (half) @(negedge CLK);
            dev_clk_low = 1'b0;
        end
        repeat (3) @(negedge CLK);
        dev_data_low = 1'b0;
    endtask

    task automatic run_xfer(input logic [7:0] d, input bit ack, input int half,
                            output logic [10:0] bits, output int ndone, output int nerr);
        int d0, e0, t;
        bit ok;
        d0 = done_cnt;
        e0 = err_cnt;
        fork
            begin
                @(negedge CLK);
                tx_data  = d;
                tx_start = 1'b1;
                @(negedge CLK);
                tx_start = 1'b0;
            end
            dev_xfer(ack, half, 11, bits, ok);
        join
        chk("request_seen", 32'(ok), 32'd1);
        t = 0;
        while (tx_busy && t < 300) begin @(negedge CLK); t++; end
        repeat (5) @(negedge CLK);
        ndone = done_cnt - d0;
        nerr  = err_cnt - e0;
    endtask

    task automatic check_xfer(input string tag, input vec_t v);
        logic [10:0] bits;
        int nd, ne;
        run_xfer(v.data, v.ack, v.half, bits, nd, ne);
        chk({tag, "_bits"}, 32'(bits), 32'(v.exp_bits));
        chk({tag, "_done"}, 32'(nd), 32'(v.exp_done));
        chk({tag, "_err"}, 32'(ne), 32'(v.exp_err));
        chk({tag, "_idle"}, 32'({tx_busy, clk_oe, data_oe}), 32'd0);
    endtask

    initial begin
        vec_t vecs[5];
        vec_t v;
        logic [10:0] bits;
        int nd, ne, cyc, n_clk, first_data, t, d0, e0;

        vecs[0] = '{8'hED, 1'b1, 20, 11'h7DA, 1, 0};
        vecs[1] = '{8'hFF, 1'b0, 15, 11'h7FE, 0, 1};
        vecs[2] = '{8'hF4, 1'b1, 12, 11'h5E8, 1, 0};
        vecs[3] = '{8'h00, 1'b1, 30, 11'h600, 1, 0};
        vecs[4] = '{8'h01, 1'b0, 10, 11'h402, 0, 1};

        RST = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
        dev_clk_low = 1'b0; dev_data_low = 1'b0;
        repeat (4) @(negedge CLK);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_err", 32'(tx_err), 32'd0);
        chk("rst_clk_oe", 32'(clk_oe), 32'd0);
        chk("rst_data_oe", 32'(data_oe), 32'd0);
        RST = 1'b0;
        repeat (3) @(negedge CLK);

        // Inhibit/request window and timeout with a silent device.
        tx_data = 8'hA5; tx_start = 1'b1;
        @(negedge CLK);
        tx_start = 1'b0;
        chk("accept_clk_oe", 32'(clk_oe), 32'd1);
        n_clk = 0; first_data = 0; cyc = 1;
        while (cyc < 100) begin
            if (!clk_oe) break;
            n_clk++;
            if (data_oe && first_data == 0) first_data = cyc;
            @(negedge CLK);
            cyc++;
        end
        chk("clk_oe_cycles", 32'(n_clk), 32'(INH + 2));
        chk("data_oe_rise_cycle", 32'(first_data), 32'(INH + 1));
        t = 0;
        while (!tx_err && t < 1000) begin @(negedge CLK); t++; end
        chk("timeout_latency", 32'(t), 32'(TMO));
        chk("timeout_release", 32'({clk_oe, data_oe}), 32'd0);
        @(negedge CLK);
        chk("err_width", 32'(tx_err), 32'd0);
        chk("err_busy", 32'(tx_busy), 32'd0);
        repeat (5) @(negedge CLK);

        for (int i = 0; i < 5; i++) check_xfer($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 8; i++) begin
            v.data     = 8'($urandom);
            v.ack      = ($urandom % 4) != 0;
            v.half     = int'($urandom_range(8, 40));
            v.exp_bits = model_frame(v.data);
            v.exp_done = v.ack ? 1 : 0;
            v.exp_err  = v.ack ? 0 : 1;
            check_xfer($sformatf("rnd%0d_%02h", i, v.data), v);
        end

        // Reset after falling edge 5 releases the lines with no pulse, then a clean frame.
        d0 = done_cnt; e0 = err_cnt;
        fork
            begin
                @(negedge CLK);
                tx_data = 8'hED; tx_start = 1'b1;
                @(negedge CLK);
                tx_start = 1'b0;
            end
            begin
                bit ok;
                dev_xfer(1'b1, 20, 5, bits, ok);
                chk("rst_req_seen", 32'(ok), 32'd1);
            end
        join
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst_clk_oe", 32'(clk_oe), 32'd0);
        chk("midrst_data_oe", 32'(data_oe), 32'd0);
        chk("midrst_busy", 32'(tx_busy), 32'd0);
        RST = 1'b0;
        repeat (30) @(negedge CLK);
        chk("midrst_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        v = '{8'hF4, 1'b1, 16, 11'h5E8, 1, 0};
        check_xfer("after_rst", v);

        // tx_start while busy must not disturb the frame in flight.
        fork
            run_xfer(8'hED, 1'b1, 20, bits, nd, ne);
            begin
                repeat (6) @(negedge CLK);
                tx_data = 8'h00; tx_start = 1'b1;
                @(negedge CLK);
                tx_start = 1'b0;
                repeat (60) @(negedge CLK);
                tx_start = 1'b1;
                @(negedge CLK);
                tx_start = 1'b0;
            end
        join
        chk("busy_ign_bits", 32'(bits), 32'h7DA);
        chk("busy_ign_done", 32'(nd), 32'd1);
        chk("busy_ign_err", 32'(ne), 32'd0);
        chk("busy_ign_idle", 32'({tx_busy, clk_oe, data_oe}), 32'd0);

        chk("done_err_overlap", 32'(both_cnt), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
